// File: rtl/hub75_bcm_scheduler.sv
// -----------------------------------------------------------------------------
// hub75_bcm_scheduler
//
// Purpose
//   Sequences a hub75_fetchshift block for binary-code-modulated display of one
//   HUB75 chain. Rows are visited in order. Each row visits bit planes 0..BITS-1,
//   and bit 0 is the plane that triggers the row fetch. The next plane is shifted
//   in while the previous plane is shown. Then the panel is blanked, the latch is
//   pulsed, and an OE window of BASE_OE<<bit cycles opens.
//
// Ports
//   sys_clk     in   system clock (sole clock)
//   rst         in   synchronous active-high reset
//   enable      in   run display; looked at only in IDLE and at the end of LATCH
//   fs_start    out  1-cycle start pulse to fetchshift
//   fs_bit_cnt  out  bit plane to shift; stable from one start to the next
//   fs_row_cnt  out  row to fetch/shift (zero-extended); stable like fs_bit_cnt
//   fs_busy     in   fetchshift busy
//   lat         out  panel latch, 1-cycle high pulse
//   oe_n        out  panel output enable, active low
//   row_addr    out  panel A..E pins; row of the currently latched data
//   frame_done  out  1-cycle pulse with the latch of the last row's last plane
//   dbg_state   out  current FSM state, for checkers and debug
//
// Handshake with fetchshift: fs_start is a single-cycle request that is only
// issued while fs_busy=0. The fetchshift then raises fs_busy for the duration
// of the shift and drops it when done. fs_bit_cnt/fs_row_cnt are qualified by
// fs_start and stay unchanged until the following LATCH, so they never move
// while fs_busy=1.
// -----------------------------------------------------------------------------
module hub75_bcm_scheduler #(
    parameter int ROWS      = 32,
    parameter int ADDR_W    = 5,
    parameter int BITS      = 8,
    parameter int BASE_OE   = 8,
    parameter int BLANK_CYC = 4,
    parameter int OE_W      = 16
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              enable,
    output logic              fs_start,
    output logic [2:0]        fs_bit_cnt,
    output logic [5:0]        fs_row_cnt,
    input  logic              fs_busy,
    output logic              lat,
    output logic              oe_n,
    output logic [ADDR_W-1:0] row_addr,
    output logic              frame_done,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_DRAIN   = 3'd4,
        S_WAIT_OE = 3'd5,
        S_BLANK   = 3'd6,
        S_LATCH   = 3'd7
    } state_t;

    // One shared cycle counter serves WAIT_HI (4), DRAIN (3) and BLANK.
    localparam int CNT_W = (BLANK_CYC > 4) ? $clog2(BLANK_CYC) : 2;

    localparam logic [CNT_W-1:0] HI_LAST    = CNT_W'(3);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [5:0]       ROW_LAST   = 6'(ROWS - 1);
    localparam logic [2:0]       BIT_LAST   = 3'(BITS - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [OE_W-1:0]   timer;
    logic [OE_W-1:0]   timer_next;
    logic [OE_W-1:0]   oe_load;
    logic              last_plane;

    assign dbg_state  = state;
    assign oe_load    = OE_W'(BASE_OE) << fs_bit_cnt;
    assign last_plane = (fs_row_cnt == ROW_LAST) && (fs_bit_cnt == BIT_LAST);

    // The OE timer runs in every state. oe_n is registered from the next timer
    // value, so it is low exactly while the timer is nonzero: the window starts
    // the cycle after LATCH and lasts BASE_OE<<bit cycles.
    always_comb begin
        timer_next = timer;
        if (state == S_LATCH) begin
            timer_next = oe_load;
        end else if (timer != '0) begin
            timer_next = timer - 1'b1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            timer      <= '0;
            fs_start   <= 1'b0;
            lat        <= 1'b0;
            frame_done <= 1'b0;
            oe_n       <= 1'b1;
            fs_bit_cnt <= '0;
            fs_row_cnt <= '0;
            row_addr   <= '0;
        end else begin
            fs_start   <= 1'b0;
            lat        <= 1'b0;
            frame_done <= 1'b0;
            timer      <= timer_next;
            oe_n       <= (timer_next == '0);

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_START;
                    end
                end

                // A fetchshift left running by an earlier reset must finish
                // before a new request is made.
                S_START: begin
                    if (!fs_busy) begin
                        fs_start <= 1'b1;
                        cnt      <= '0;
                        state    <= S_WAIT_HI;
                    end
                end

                // Guard: if busy never shows within 4 cycles, carry on so a
                // dead fetchshift cannot stall the display.
                S_WAIT_HI: begin
                    if (fs_busy || (cnt == HI_LAST)) begin
                        state <= S_WAIT_LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_WAIT_LO: begin
                    if (!fs_busy) begin
                        cnt   <= '0;
                        state <= S_DRAIN;
                    end
                end

                // Lets the fetchshift's 2-stage registered clk/data settle.
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state <= S_WAIT_OE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Leave as the window runs out (timer about to reach 0), so the
                // first BLANK cycle is also the first dark cycle and the latch
                // follows the end of the window by exactly BLANK_CYC cycles.
                S_WAIT_OE: begin
                    if (timer <= OE_W'(1)) begin
                        cnt   <= '0;
                        state <= S_BLANK;
                    end
                end

                S_BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        lat        <= 1'b1;
                        frame_done <= last_plane;
                        state      <= S_LATCH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_LATCH: begin
                    row_addr <= fs_row_cnt[ADDR_W-1:0];
                    if (fs_bit_cnt == BIT_LAST) begin
                        fs_bit_cnt <= '0;
                        fs_row_cnt <= (fs_row_cnt == ROW_LAST) ? 6'd0 : fs_row_cnt + 6'd1;
                    end else begin
                        fs_bit_cnt <= fs_bit_cnt + 3'd1;
                    end
                    state <= enable ? S_START : S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
